// File: rtl/core_clk_reset_seq.sv
// Core reset sequencer and 6.7 MHz clock-enable generator for the 53.6 MHz core domain.
// Optional macro CORE_CE_PAUSE_EN adds a 'pause' input that freezes the enables in RUN.
module core_clk_reset_seq #(
  parameter int SYNC_STAGES        = 2,
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int RESET_HOLD_CYCLES  = 16,
  parameter int CE_DIV             = 8,
  parameter int CE_Q_OFFSET        = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       pll_locked,
  input  logic       reset_req,
`ifdef CORE_CE_PAUSE_EN
  input  logic       pause,
`endif
  output logic       core_reset_n,
  output logic       ce_pix,
  output logic       ce_pix_q,
  output logic [1:0] seq_state,
  output logic       lock_lost,
  output logic [7:0] lock_loss_cnt
);

  localparam int CNT_MAX = (LOCK_STABLE_CYCLES > RESET_HOLD_CYCLES) ? LOCK_STABLE_CYCLES
                                                                    : RESET_HOLD_CYCLES;
  localparam int CNT_W = $clog2(CNT_MAX + 1);
  localparam int PH_W  = (CE_DIV > 1) ? $clog2(CE_DIV) : 1;

  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(RESET_HOLD_CYCLES - 1);
  localparam logic [PH_W-1:0]  PH_LAST   = PH_W'(CE_DIV - 1);
  localparam logic [PH_W-1:0]  PH_Q      = PH_W'(CE_Q_OFFSET);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABILIZE = 2'd1,
    HOLD      = 2'd2,
    RUN       = 2'd3
  } state_t;

  state_t                 state, state_next;
  logic [CNT_W-1:0]       cnt, cnt_next;
  logic [PH_W-1:0]        phase, phase_next;
  logic [SYNC_STAGES-1:0] lock_sync, req_sync;
  logic                   lock_s, req_s;
  logic                   in_active, div_active, paused, drop;

  assign lock_s    = lock_sync[SYNC_STAGES-1];
  assign req_s     = req_sync[SYNC_STAGES-1];
  assign seq_state = state;

  // A state only stays in HOLD/RUN while lock_s is high, so lock_s low there is a 1->0 drop.
  assign in_active  = (state == HOLD) || (state == RUN);
  assign drop       = in_active && !lock_s;
  assign div_active = in_active && lock_s;

`ifdef CORE_CE_PAUSE_EN
  assign paused = pause && (state == RUN);
`else
  assign paused = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lock_sync <= '0;
      req_sync  <= '0;
    end else begin
      lock_sync <= {lock_sync[SYNC_STAGES-2:0], pll_locked};
      req_sync  <= {req_sync[SYNC_STAGES-2:0], reset_req};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= WAIT_LOCK;
      cnt          <= '0;
      core_reset_n <= 1'b0;
    end else begin
      state        <= state_next;
      cnt          <= cnt_next;
      core_reset_n <= (state_next == RUN);
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      WAIT_LOCK: begin
        cnt_next = '0;
        if (lock_s) state_next = STABILIZE;
      end
      STABILIZE: begin
        if (!lock_s) begin
          state_next = WAIT_LOCK;
          cnt_next   = '0;
        end else if (cnt == LOCK_LAST) begin
          state_next = HOLD;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      HOLD: begin
        if (!lock_s) begin
          state_next = WAIT_LOCK;
          cnt_next   = '0;
        end else if (req_s) begin
          cnt_next = '0;
        end else if (cnt == HOLD_LAST) begin
          state_next = RUN;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      RUN: begin
        cnt_next = '0;
        if (!lock_s) state_next = WAIT_LOCK;
        else if (req_s) state_next = HOLD;
      end
      default: begin
        state_next = WAIT_LOCK;
        cnt_next   = '0;
      end
    endcase
  end

  // Divider keeps running across RUN->HOLD so the enable cadence is unbroken by soft resets.
  always_comb begin
    phase_next = phase;
    if (!div_active) phase_next = '0;
    else if (!paused) phase_next = (phase == PH_LAST) ? '0 : phase + 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phase    <= '0;
      ce_pix   <= 1'b0;
      ce_pix_q <= 1'b0;
    end else begin
      phase    <= phase_next;
      ce_pix   <= div_active && !paused && (phase == '0);
      ce_pix_q <= div_active && !paused && (phase == PH_Q);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lock_lost     <= 1'b0;
      lock_loss_cnt <= '0;
    end else if (drop) begin
      lock_lost <= 1'b1;
      if (lock_loss_cnt != 8'hFF) lock_loss_cnt <= lock_loss_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_core_clk_reset_seq.sv
// Directed bench for core_clk_reset_seq: default-parameter sequencer plus a short-timing
// instance used for lock-loss counter saturation.
module tb_core_clk_reset_seq;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       pll_locked = 1'b0;
  logic       reset_req = 1'b0;
  logic       pll_s = 1'b0;
`ifdef CORE_CE_PAUSE_EN
  logic       pause = 1'b0;
  logic       pause_s = 1'b0;
`endif
  logic       core_reset_n, ce_pix, ce_pix_q, lock_lost;
  logic [1:0] seq_state;
  logic [7:0] lock_loss_cnt;
  logic       crn_s, ce_s, ceq_s, lost_s;
  logic [1:0] st_s;
  logic [7:0] cnt_s;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int ce_base  = 0;

  typedef struct {
    int         cyc;
    logic [1:0] st;
    logic       crn;
    logic       ce;
    logic       ceq;
  } vec_t;
  vec_t tbl[15];

  always #5 clk = ~clk;

  core_clk_reset_seq dut (
    .clk(clk), .reset_n(reset_n), .pll_locked(pll_locked), .reset_req(reset_req),
`ifdef CORE_CE_PAUSE_EN
    .pause(pause),
`endif
    .core_reset_n(core_reset_n), .ce_pix(ce_pix), .ce_pix_q(ce_pix_q),
    .seq_state(seq_state), .lock_lost(lock_lost), .lock_loss_cnt(lock_loss_cnt)
  );

  core_clk_reset_seq #(.LOCK_STABLE_CYCLES(4), .RESET_HOLD_CYCLES(4)) dut_s (
    .clk(clk), .reset_n(reset_n), .pll_locked(pll_s), .reset_req(1'b0),
`ifdef CORE_CE_PAUSE_EN
    .pause(pause_s),
`endif
    .core_reset_n(crn_s), .ce_pix(ce_s), .ce_pix_q(ceq_s),
    .seq_state(st_s), .lock_lost(lost_s), .lock_loss_cnt(cnt_s)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d, t=%0t)", name, act, exp, cyc, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic steps(input int n);
    repeat (n) step();
  endtask

  // Expected cadence: ce_pix at ce_base + 8k, ce_pix_q two cycles after each.
  task automatic check_cadence(input string tag);
    int d;
    d = (cyc - ce_base) % 8;
    check({tag, "_ce"},  32'(ce_pix),   32'(d == 0));
    check({tag, "_ceq"}, 32'(ce_pix_q), 32'(d == 2));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_crn"},  32'(core_reset_n),  0);
    check({tag, "_ce"},   32'(ce_pix),        0);
    check({tag, "_ceq"},  32'(ce_pix_q),      0);
    check({tag, "_st"},   32'(seq_state),     0);
    check({tag, "_lost"}, 32'(lock_lost),     0);
    check({tag, "_cnt"},  32'(lock_loss_cnt), 0);
  endtask

  initial begin
    int exp_cnt;
    tbl[0]  = '{1,    2'd0, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{2,    2'd0, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{3,    2'd1, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{500,  2'd1, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{1026, 2'd1, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{1027, 2'd2, 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{1028, 2'd2, 1'b0, 1'b1, 1'b0};
    tbl[7]  = '{1029, 2'd2, 1'b0, 1'b0, 1'b0};
    tbl[8]  = '{1030, 2'd2, 1'b0, 1'b0, 1'b1};
    tbl[9]  = '{1036, 2'd2, 1'b0, 1'b1, 1'b0};
    tbl[10] = '{1038, 2'd2, 1'b0, 1'b0, 1'b1};
    tbl[11] = '{1042, 2'd2, 1'b0, 1'b0, 1'b0};
    tbl[12] = '{1043, 2'd3, 1'b1, 1'b0, 1'b0};
    tbl[13] = '{1044, 2'd3, 1'b1, 1'b1, 1'b0};
    tbl[14] = '{1046, 2'd3, 1'b1, 1'b0, 1'b1};

    // Reset state
    steps(3);
    check_all_zero("rst");
    reset_n = 1'b1;
    steps(5);
    check_all_zero("idle");

    // Unstable lock: drop during STABILIZE returns to WAIT_LOCK without counting
    pll_locked = 1'b1;
    steps(500);
    check("unstable_st_before", 32'(seq_state), 1);
    pll_locked = 1'b0;
    steps(3);
    check("unstable_st_after", 32'(seq_state), 0);
    check("unstable_crn", 32'(core_reset_n), 0);

    // Power-up sequence timed from the final pll_locked rise
    pll_locked = 1'b1;
    cyc = 0;
    for (int i = 0; i < 15; i++) begin
      while (cyc < tbl[i].cyc) step();
      check($sformatf("pwr%0d_st", i),   32'(seq_state),    32'(tbl[i].st));
      check($sformatf("pwr%0d_crn", i),  32'(core_reset_n), 32'(tbl[i].crn));
      check($sformatf("pwr%0d_ce", i),   32'(ce_pix),       32'(tbl[i].ce));
      check($sformatf("pwr%0d_ceq", i),  32'(ce_pix_q),     32'(tbl[i].ceq));
      check($sformatf("pwr%0d_lost", i), 32'(lock_lost),    0);
      check($sformatf("pwr%0d_cnt", i),  32'(lock_loss_cnt), 0);
    end
    ce_base = 1028;
    repeat (40) begin
      step();
      check_cadence("run");
      check("run_crn", 32'(core_reset_n), 1);
    end

    // Soft reset: 40 cycles of reset_req in RUN
    reset_req = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      step();
      check_cadence("req");
      check("req_crn", 32'(core_reset_n), 32'(k < 3));
      check("req_st",  32'(seq_state),    (k < 3) ? 3 : 2);
    end
    reset_req = 1'b0;
    for (int k = 1; k <= 18; k++) begin
      step();
      check_cadence("rel");
      check("rel_crn", 32'(core_reset_n), 32'(k == 18));
    end
    check("rel_st", 32'(seq_state), 3);

`ifdef CORE_CE_PAUSE_EN
    // Pause in RUN freezes the divider; cadence resumes shifted by the pause length
    pause = 1'b1;
    repeat (13) begin
      step();
      check("pause_ce",  32'(ce_pix),   0);
      check("pause_ceq", 32'(ce_pix_q), 0);
    end
    pause = 1'b0;
    ce_base += 13;
    repeat (24) begin
      step();
      check_cadence("unpause");
    end
`endif

    // Lock loss in RUN
    pll_locked = 1'b0;
    step();
    check("loss1_crn", 32'(core_reset_n), 1);
    step();
    check("loss2_crn", 32'(core_reset_n), 1);
    step();
    check("loss3_crn",  32'(core_reset_n),  0);
    check("loss3_st",   32'(seq_state),     0);
    check("loss3_ce",   32'(ce_pix),        0);
    check("loss3_ceq",  32'(ce_pix_q),      0);
    check("loss3_lost", 32'(lock_lost),     1);
    check("loss3_cnt",  32'(lock_loss_cnt), 1);
    repeat (20) begin
      step();
      check("loss_ce",  32'(ce_pix),   0);
      check("loss_ceq", 32'(ce_pix_q), 0);
    end

    // Re-lock repeats the full sequence
    pll_locked = 1'b1;
    cyc = 0;
    steps(1042);
    check("relock_crn_early", 32'(core_reset_n), 0);
    check("relock_st_early",  32'(seq_state),    2);
    step();
    check("relock_crn", 32'(core_reset_n), 1);
    check("relock_st",  32'(seq_state),    3);
    check("relock_lost", 32'(lock_lost),   1);
    check("relock_cnt", 32'(lock_loss_cnt), 1);

    // Saturation on the short-timing instance
    exp_cnt = 0;
    for (int k = 0; k < 300; k++) begin
      pll_s = 1'b1;
      steps(10);
      check("sat_st_hold", 32'(st_s), 2);
      pll_s = 1'b0;
      steps(5);
      exp_cnt = (exp_cnt == 255) ? 255 : exp_cnt + 1;
      check("sat_cnt", 32'(cnt_s), 32'(exp_cnt));
    end
    check("sat_lost", 32'(lost_s), 1);
    check("sat_final", 32'(cnt_s), 255);

    // Asynchronous reset mid-operation (main instance in RUN)
    check("pre_rst_crn", 32'(core_reset_n), 1);
    #2;
    reset_n = 1'b0;
    #1;
    check_all_zero("midrst");
    check("midrst_s_cnt",  32'(cnt_s),  0);
    check("midrst_s_lost", 32'(lost_s), 0);
    check("midrst_s_crn",  32'(crn_s),  0);
    steps(3);
    check_all_zero("midrst_hold");
    reset_n = 1'b1;
    steps(2);
    check("post_rst_st",  32'(seq_state),    0);
    check("post_rst_crn", 32'(core_reset_n), 0);
    steps(1);
    check("post_rst_stab", 32'(seq_state), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
